// File: rtl/emif_master_z_if.sv
// Request/response handshake and EMIF control outputs of the EMIF master.
// The tri-state data bus stays a plain module port so it resolves as an ordinary net.
interface emif_master_z_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [23:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [23:0] emif_addr_o;
   logic [1:0]  emif_byten_o;
   logic        emif_cen_o;
   logic        emif_wen_o;
   logic        emif_oen_o;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata,
      output emif_addr_o, emif_byten_o, emif_cen_o, emif_wen_o, emif_oen_o
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  emif_addr_o, emif_byten_o, emif_cen_o, emif_wen_o, emif_oen_o
   );
endinterface

// File: rtl/emif_master_z.sv
// Asynchronous-SRAM style EMIF master: one single-word read or write per request,
// with programmable setup/strobe/hold/turnaround timing.
//
// state    | meaning
// IDLE     | req_ready high, bus released, waiting for a request
// SETUP    | CE/address/byte enables valid, strobes still high
// STROBE   | WE# (write) or OE# (read) low
// HOLD     | strobe high again, CE/address/write data still held
// TURN     | CE high, bus released; rsp_valid on the first cycle
module emif_master_z #(
   parameter int SETUP  = 2,
   parameter int STROBE = 4,
   parameter int HOLD   = 4,
   parameter int TA     = 2
) (
   input  logic                 clk_ref,
   input  logic                 rst,
   emif_master_z_if.master      ifc,
   inout  wire  [15:0]          emif_data_z
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_TURN
   } state_t;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);
   localparam logic [3:0] TA_LD     = 4'(TA - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept;
   logic        active_nxt;
   logic        we_nxt;
   logic        we_q;
   logic [15:0] wdata_q;
   logic        drive;

   assign ifc.req_ready = (state == S_IDLE);
   assign emif_data_z   = drive ? wdata_q : 16'hzzzz;

   // Each timed state loads its length minus one on entry and leaves at zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (ifc.req_valid) begin
               accept    = 1'b1;
               state_nxt = S_SETUP;
               cnt_nxt   = SETUP_LD;
            end
         end
         S_SETUP: begin
            if (cnt == 4'd0) begin
               state_nxt = S_STROBE;
               cnt_nxt   = STROBE_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_STROBE: begin
            if (cnt == 4'd0) begin
               state_nxt = S_HOLD;
               cnt_nxt   = HOLD_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_HOLD: begin
            if (cnt == 4'd0) begin
               state_nxt = S_TURN;
               cnt_nxt   = TA_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_TURN: begin
            if (cnt == 4'd0) begin
               state_nxt = S_IDLE;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
      active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_HOLD);
      we_nxt     = accept ? ifc.req_we : we_q;
   end

   // Pins are decoded from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk_ref) begin
      if (rst) begin
         state            <= S_IDLE;
         cnt              <= 4'd0;
         we_q             <= 1'b0;
         wdata_q          <= 16'h0000;
         drive            <= 1'b0;
         ifc.rsp_valid    <= 1'b0;
         ifc.rsp_rdata    <= 16'h0000;
         ifc.emif_addr_o  <= 24'h000000;
         ifc.emif_byten_o <= 2'b11;
         ifc.emif_cen_o   <= 1'b1;
         ifc.emif_wen_o   <= 1'b1;
         ifc.emif_oen_o   <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            we_q            <= ifc.req_we;
            wdata_q         <= ifc.req_wdata;
            ifc.emif_addr_o <= {ifc.req_addr[0], ifc.req_addr[23:1]};
         end
         drive            <= active_nxt && we_nxt;
         ifc.emif_cen_o   <= ~active_nxt;
         ifc.emif_byten_o <= active_nxt ? 2'b00 : 2'b11;
         ifc.emif_wen_o   <= ~((state_nxt == S_STROBE) && we_nxt);
         ifc.emif_oen_o   <= ~((state_nxt == S_STROBE) && !we_nxt);
         ifc.rsp_valid    <= (state == S_HOLD) && (state_nxt == S_TURN);
         if ((state == S_STROBE) && (cnt == 4'd0) && !we_q)
            ifc.rsp_rdata <= emif_data_z;
      end
   end

endmodule

// File: tb/tb_emif_master_z.sv
// Directed bench for emif_master_z: a default-timing instance and a minimum-timing
// instance, both checked every cycle against a cycle-offset model of the transaction.
module tb_emif_master_z;

   logic clk_ref = 1'b0;
   logic rst     = 1'b1;
   always #5 clk_ref = ~clk_ref;

   emif_master_z_if ifa ();
   emif_master_z_if ifb ();
   wire  [15:0] bus_a;
   wire  [15:0] bus_b;
   logic [15:0] rdv_a = 16'h0000;
   logic [15:0] rdv_b = 16'h0000;

   // Memory model: drives read data only while OE# is low.
   assign bus_a = (ifa.emif_oen_o == 1'b0) ? rdv_a : 16'hzzzz;
   assign bus_b = (ifb.emif_oen_o == 1'b0) ? rdv_b : 16'hzzzz;

   emif_master_z dut_a (.clk_ref(clk_ref), .rst(rst), .ifc(ifa), .emif_data_z(bus_a));
   emif_master_z #(.SETUP(1), .STROBE(1), .HOLD(1), .TA(1))
      dut_b (.clk_ref(clk_ref), .rst(rst), .ifc(ifb), .emif_data_z(bus_b));

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit chk_en      = 1'b0;

   // Cycle n is the period ending at rising edge n; during it cyc == n-1.
   always @(posedge clk_ref) cyc <= cyc + 1;

   typedef struct {
      bit          busy;
      int          k;
      bit          we;
      logic [23:0] eaddr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } mdl_t;

   typedef struct {
      bit       ready;
      bit       rsp;
      bit       cen;
      bit       wen;
      bit       oen;
      bit       drive;
      bit [1:0] byten;
   } exp_t;

   mdl_t ma = '{busy: 1'b0, k: 0, we: 1'b0, eaddr: 24'h0, wdata: 16'h0, rdata: 16'h0};
   mdl_t mb = '{busy: 1'b0, k: 0, we: 1'b0, eaddr: 24'h0, wdata: 16'h0, rdata: 16'h0};

   function automatic exp_t predict(mdl_t m, int c, int s, int st, int h, int t);
      exp_t p;
      int   d;
      bit   act, strobe;
      d      = c - m.k;
      act    = m.busy && (d >= 1) && (d <= s + st + h);
      strobe = act && (d > s) && (d <= s + st);
      p.cen   = !act;
      p.byten = act ? 2'b00 : 2'b11;
      p.wen   = !(strobe && m.we);
      p.oen   = !(strobe && !m.we);
      p.drive = act && m.we;
      p.rsp   = m.busy && (d == s + st + h + 1);
      p.ready = !m.busy || (d >= s + st + h + t + 1);
      return p;
   endfunction

   // Advance the model across rising edge e (the edge that ends cycle e).
   function automatic mdl_t step(mdl_t m, int e, bit r, bit valid, bit we,
                                 logic [23:0] addr, logic [15:0] wd, logic [15:0] rdv,
                                 int s, int st, int h, int t);
      mdl_t n;
      exp_t p;
      n = m;
      p = predict(m, e, s, st, h, t);
      if (r) begin
         n.busy  = 1'b0;
         n.eaddr = 24'h0;
         n.rdata = 16'h0;
         return n;
      end
      if (m.busy && !p.oen && (e - m.k == s + st))
         n.rdata = rdv;
      if (p.ready && valid) begin
         n.busy  = 1'b1;
         n.k     = e;
         n.we    = we;
         n.wdata = wd;
         n.eaddr = {addr[0], addr[23:1]};
      end
      return n;
   endfunction

   always @(posedge clk_ref) begin
      ma <= step(ma, cyc + 1, rst, ifa.req_valid, ifa.req_we, ifa.req_addr, ifa.req_wdata,
                 rdv_a, 2, 4, 4, 2);
      mb <= step(mb, cyc + 1, rst, ifb.req_valid, ifb.req_we, ifb.req_addr, ifb.req_wdata,
                 rdv_b, 1, 1, 1, 1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input string tag, input exp_t p, input mdl_t m,
                            input logic ready, input logic rsp, input logic [15:0] rdata,
                            input logic [23:0] addr, input logic [1:0] byten,
                            input logic cen, input logic wen, input logic oen,
                            input logic [15:0] bus, input logic [15:0] rdv);
      chk({tag, ".req_ready"}, 32'(ready), 32'(p.ready));
      chk({tag, ".rsp_valid"}, 32'(rsp), 32'(p.rsp));
      chk({tag, ".rsp_rdata"}, 32'(rdata), 32'(m.rdata));
      chk({tag, ".addr"}, 32'(addr), 32'(m.eaddr));
      chk({tag, ".byten"}, 32'(byten), 32'(p.byten));
      chk({tag, ".cen"}, 32'(cen), 32'(p.cen));
      chk({tag, ".wen"}, 32'(wen), 32'(p.wen));
      chk({tag, ".oen"}, 32'(oen), 32'(p.oen));
      if (p.drive) begin
         chk({tag, ".bus_wdata"}, 32'(bus), 32'(m.wdata));
      end else if (!p.oen) begin
         chk({tag, ".bus_rdata"}, 32'(bus), 32'(rdv));
      end else begin
         vectors++;
         if (!(bus === 16'hzzzz || bus === 16'h0000)) begin
            miscompares++;
            $display("FAIL %s.bus_released: got %h, want zzzz (t=%0t)", tag, bus, $time);
         end
      end
   endtask

   always @(negedge clk_ref) begin
      if (chk_en) begin
         check_dut("a", predict(ma, cyc + 1, 2, 4, 4, 2), ma, ifa.req_ready, ifa.rsp_valid,
                   ifa.rsp_rdata, ifa.emif_addr_o, ifa.emif_byten_o, ifa.emif_cen_o,
                   ifa.emif_wen_o, ifa.emif_oen_o, bus_a, rdv_a);
         check_dut("b", predict(mb, cyc + 1, 1, 1, 1, 1), mb, ifb.req_ready, ifb.rsp_valid,
                   ifb.rsp_rdata, ifb.emif_addr_o, ifb.emif_byten_o, ifb.emif_cen_o,
                   ifb.emif_wen_o, ifb.emif_oen_o, bus_b, rdv_b);
      end
   end

   function automatic bit get_ready(input bit sel);
      return sel ? ifb.req_ready : ifa.req_ready;
   endfunction

   function automatic bit get_rsp(input bit sel);
      return sel ? ifb.rsp_valid : ifa.rsp_valid;
   endfunction

   task automatic set_req(input bit sel, input bit valid, input bit we,
                          input logic [23:0] addr, input logic [15:0] wd);
      if (sel) begin
         ifb.req_valid = valid; ifb.req_we = we; ifb.req_addr = addr; ifb.req_wdata = wd;
      end else begin
         ifa.req_valid = valid; ifa.req_we = we; ifa.req_addr = addr; ifa.req_wdata = wd;
      end
   endtask

   // Present a request and return once accepted; k is the accepting edge and the
   // task returns at the negedge of cycle k+1 with req_valid still high.
   task automatic issue(input bit sel, input bit we, input logic [23:0] addr,
                        input logic [15:0] wd, output int k);
      k = -1;
      @(negedge clk_ref);
      set_req(sel, 1'b1, we, addr, wd);
      for (int i = 0; i < 40; i++) begin
         if (get_ready(sel)) begin
            k = cyc + 1;
            break;
         end
         @(negedge clk_ref);
      end
      if (k < 0) chk("issue_timeout", 32'd1, 32'd0);
      @(negedge clk_ref);
   endtask

   // Returns the cycle number of the first negedge (from now) where rsp_valid or req_ready is high.
   task automatic wait_sig(input bit sel, input bit want_ready, output int c);
      c = -1;
      for (int i = 0; i < 40; i++) begin
         if (want_ready ? get_ready(sel) : get_rsp(sel)) begin
            c = cyc + 1;
            break;
         end
         @(negedge clk_ref);
      end
   endtask

   int k, k2, c, turn, pulses;

   initial begin
      set_req(1'b0, 1'b0, 1'b0, 24'h0, 16'h0);
      set_req(1'b1, 1'b0, 1'b0, 24'h0, 16'h0);
      repeat (2) @(posedge clk_ref);
      @(negedge clk_ref);
      chk_en = 1'b1;
      chk("reset_ready", 32'(ifa.req_ready), 32'd1);
      chk("reset_rdata", 32'(ifa.rsp_rdata), 32'h0);
      rst = 1'b0;

      // Write with default timing
      issue(1'b0, 1'b1, 24'h000123, 16'hA5A5, k);
      ifa.req_valid = 1'b0;
      chk("wr_addr", 32'(ifa.emif_addr_o), 32'h800091);
      chk("wr_cen_k1", 32'(ifa.emif_cen_o), 32'd0);
      chk("wr_bus_k1", 32'(bus_a), 32'hA5A5);
      repeat (2) @(negedge clk_ref);
      chk("wr_wen_k3", 32'(ifa.emif_wen_o), 32'd0);
      wait_sig(1'b0, 1'b0, c);
      chk("wr_rsp_cycle", 32'(c), 32'(k + 11));
      wait_sig(1'b0, 1'b1, c);
      chk("wr_ready_cycle", 32'(c), 32'(k + 13));

      // Read with default timing; request wdata is nonzero so a stray drive shows up
      rdv_a = 16'h5A3C;
      issue(1'b0, 1'b0, 24'h000456, 16'hFFFF, k);
      ifa.req_valid = 1'b0;
      repeat (2) @(negedge clk_ref);
      chk("rd_oen_k3", 32'(ifa.emif_oen_o), 32'd0);
      wait_sig(1'b0, 1'b0, c);
      chk("rd_rsp_cycle", 32'(c), 32'(k + 11));
      chk("rd_rdata", 32'(ifa.rsp_rdata), 32'h5A3C);
      wait_sig(1'b0, 1'b1, c);
      chk("rd_ready_cycle", 32'(c), 32'(k + 13));

      // Back-to-back: write then read with req_valid held throughout
      rdv_a = 16'hC3C3;
      issue(1'b0, 1'b1, 24'h00ABCD, 16'h1357, k);
      set_req(1'b0, 1'b1, 1'b0, 24'hFFFFFF, 16'hFFFF);
      k2 = -1;
      turn = 0;
      for (int i = 0; i < 40; i++) begin
         if (ifa.req_ready) begin
            k2 = cyc + 1;
            break;
         end
         if (ifa.emif_cen_o) turn++;
         @(negedge clk_ref);
      end
      chk("b2b_accept_edge", 32'(k2), 32'(k + 13));
      chk("b2b_turn_cycles", 32'(turn), 32'd2);
      @(negedge clk_ref);
      ifa.req_valid = 1'b0;
      wait_sig(1'b0, 1'b1, c);
      chk("b2b_ready_cycle", 32'(c), 32'(k2 + 13));
      chk("b2b_rdata", 32'(ifa.rsp_rdata), 32'hC3C3);

      // Reset in the middle of a write strobe
      rdv_a = 16'h0000;
      issue(1'b0, 1'b1, 24'h0000F0, 16'h0F0F, k);
      ifa.req_valid = 1'b0;
      repeat (3) @(negedge clk_ref);
      chk("abort_wen_before", 32'(ifa.emif_wen_o), 32'd0);
      rst = 1'b1;
      @(negedge clk_ref);
      rst = 1'b0;
      chk("abort_wen", 32'(ifa.emif_wen_o), 32'd1);
      chk("abort_cen", 32'(ifa.emif_cen_o), 32'd1);
      chk("abort_ready", 32'(ifa.req_ready), 32'd1);
      chk("abort_rdata", 32'(ifa.rsp_rdata), 32'h0);
      chk("abort_addr", 32'(ifa.emif_addr_o), 32'h0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (ifa.rsp_valid) pulses++;
         @(negedge clk_ref);
      end
      chk("abort_no_rsp", 32'(pulses), 32'd0);

      // Minimum timing instance: read then write
      rdv_b = 16'h1E1E;
      issue(1'b1, 1'b0, 24'h800001, 16'hFFFF, k);
      ifb.req_valid = 1'b0;
      wait_sig(1'b1, 1'b0, c);
      chk("fast_rsp_cycle", 32'(c), 32'(k + 4));
      chk("fast_rdata", 32'(ifb.rsp_rdata), 32'h1E1E);
      chk("fast_addr", 32'(ifb.emif_addr_o), 32'hC00000);
      wait_sig(1'b1, 1'b1, c);
      chk("fast_ready_cycle", 32'(c), 32'(k + 5));
      issue(1'b1, 1'b1, 24'h000010, 16'h7E7E, k);
      ifb.req_valid = 1'b0;
      wait_sig(1'b1, 1'b1, c);
      chk("fast_wr_ready_cycle", 32'(c), 32'(k + 5));

      repeat (4) @(negedge clk_ref);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
